tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single AVR USB serial transmit port between several message producers (debug telemetry, command echo, status reports). Each producer exposes a byte-addressable message and raises a request; the arbiter grants one producer at a time, walks its message byte by byte under the `tx_busy` handshake, and pulses a per-requester completion flag. It sits between the message-building blocks and the AVR interface's `tx_data`/`new_tx_data`/`tx_busy` ports.

---
 rtl/tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin owner of the AVR serial transmit port.
// Walks the granted requester's message one byte per tx_busy handshake and pulses done.
module tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_BITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*ADDR_BITS-1:0] len,
  input  logic [NREQ*8-1:0]         msg_data,
  output logic [ADDR_BITS-1:0]      rd_addr,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  input  logic                      tx_busy,
  output logic [7:0]                tx_data,
  output logic                      new_tx_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        rr_cand;
  logic                 win_found;
  logic [NREQ-1:0]      win_onehot;
  logic [ADDR_BITS-1:0] len_q;
  logic [7:0]           msg_arr [NREQ];
  logic [ADDR_BITS-1:0] len_arr [NREQ];
  logic                 start;
  logic                 issue;
  logic                 last;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      msg_arr[i] = msg_data[i*8 +: 8];
      len_arr[i] = len[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Scan backwards so the candidate closest after ptr is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_cand = IW'((int'(ptr) + k) % NREQ);
      if (req[rr_cand]) begin
        win_found = 1'b1;
        win_idx   = rr_cand;
      end
    end
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

  // The done pulse cycle is not an arbitration cycle: the finished requester still holds req.
  assign start = (state == IDLE) && win_found && (done == '0);
  assign issue = (state == SEND) && !tx_busy && !new_tx_data;
  assign last  = (rd_addr == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (issue && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= IW'(NREQ - 1);
      owner       <= '0;
      grant       <= '0;
      done        <= '0;
      rd_addr     <= '0;
      len_q       <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      done        <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            grant   <= win_onehot;
            owner   <= win_idx;
            rd_addr <= '0;
            len_q   <= len_arr[win_idx];
          end
        end
        SEND: begin
          if (issue) begin
            tx_data     <= msg_arr[owner];
            new_tx_data <= 1'b1;
            if (!last) begin
              rd_addr <= rd_addr + ADDR_BITS'(1);
            end
          end
        end
        DONE: begin
          done    <= grant;
          grant   <= '0;
          ptr     <= owner;
          rd_addr <= '0;
        end
        default: begin
          grant   <= '0;
          rd_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter.
// Expected grants, bytes and message lengths are queued at stimulus time and popped by a monitor.
module tb_tx_arbiter;

  localparam int NREQ = 4;
  localparam int AB   = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*AB-1:0]   len;
  logic [NREQ*8-1:0]    msg_data;
  logic [AB-1:0]        rd_addr;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 tx_busy = 1'b0;
  logic [7:0]           tx_data;
  logic                 new_tx_data;

  logic [7:0]           mem [NREQ][32];
  logic [AB-1:0]        len_val [NREQ];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [7:0]      exp_bytes [$];
  logic [NREQ-1:0] exp_grant [$];
  int              exp_len   [$];
  int              strobe_log [$];
  int              done_log   [$];
  int              grant_log  [$];
  logic [NREQ-1:0] cur_owner = '0;
  int              cur_len   = 0;
  int              strobe_cnt = 0;
  logic [AB-1:0]   last_addr = '0;
  logic [NREQ-1:0] grant_prev = '0;
  logic            busy_q = 1'b0;

  tx_arbiter #(.NREQ(NREQ), .ADDR_BITS(AB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .len         (len),
    .msg_data    (msg_data),
    .rd_addr     (rd_addr),
    .grant       (grant),
    .done        (done),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data)
  );

  always #5 clk = ~clk;

  // Requesters present their byte at rd_addr combinationally.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      msg_data[i*8 +: 8] = mem[i][rd_addr];
      len[i*AB +: AB]    = len_val[i];
    end
  end

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= tx_busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops expectations as the DUT produces grants, bytes and done pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (grant != '0 && grant_prev == '0) begin
        grant_log.push_back(cyc - t0);
        strobe_cnt = 0;
        checkOutput("grant_onehot", 32'($countones(grant)), 32'd1);
        if (exp_grant.size() == 0) begin
          checkOutput("unexpected_grant", 32'(grant), 32'hFFFF_FFFF);
        end else begin
          cur_owner = exp_grant.pop_front();
          cur_len   = exp_len.pop_front();
          checkOutput("grant_owner", 32'(grant), 32'(cur_owner));
        end
      end
      if (new_tx_data) begin
        strobe_cnt++;
        strobe_log.push_back(cyc - t0);
        last_addr = rd_addr;
        checkOutput("strobe_not_busy", 32'(busy_q), 32'd0);
        if (exp_bytes.size() == 0) begin
          checkOutput("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          checkOutput("tx_data", 32'(tx_data), 32'(exp_bytes.pop_front()));
        end
      end
      if (done != '0) begin
        done_log.push_back(cyc - t0);
        checkOutput("done_owner", 32'(done), 32'(cur_owner));
        checkOutput("msg_len", 32'(strobe_cnt), 32'(cur_len));
        checkOutput("done_vs_strobe", 32'(new_tx_data), 32'd0);
      end
      grant_prev = grant;
    end else begin
      grant_prev = '0;
    end
  end

  task automatic clearScoreboard();
    exp_bytes.delete();
    exp_grant.delete();
    exp_len.delete();
    strobe_log.delete();
    done_log.delete();
    grant_log.delete();
  endtask

  task automatic resetDut();
    rst     = 1'b0;
    req     = '0;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    clearScoreboard();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pushMsg(input int i);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    exp_grant.push_back(oh);
    exp_len.push_back(int'(len_val[i]) + 1);
    for (int a = 0; a <= int'(len_val[i]); a++) begin
      exp_bytes.push_back(mem[i][a]);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] mask);
    t0  = cyc;
    req = req | mask;
  endtask

  task automatic waitQuiet(input int budget, input bit auto_drop);
    bit quiet;
    quiet = 1'b0;
    for (int n = 0; n < budget && !quiet; n++) begin
      @(negedge clk);
      if (auto_drop && done != '0) begin
        req = req & ~done;
      end
      if (exp_bytes.size() == 0 && exp_grant.size() == 0 && grant == '0 && done == '0) begin
        quiet = 1'b1;
      end
    end
    if (!quiet) begin
      checkOutput("timeout_quiet", 32'd0, 32'd1);
    end
  endtask

  task automatic waitStrobes(input int count, input int budget);
    int seen;
    seen = 0;
    for (int n = 0; n < budget && seen < count; n++) begin
      @(negedge clk);
      if (new_tx_data) begin
        seen++;
      end
    end
    if (seen < count) begin
      checkOutput("timeout_strobe", 32'(seen), 32'(count));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;

    for (int i = 0; i < NREQ; i++) begin
      len_val[i] = '0;
      for (int a = 0; a < 32; a++) begin
        mem[i][a] = 8'(8'h80 + i*32 + a);
      end
    end
    mem[0][0] = 8'h41;
    mem[0][1] = 8'h42;
    mem[0][2] = 8'h43;
    mem[0][3] = 8'h44;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 32'({grant, done, rd_addr, tx_data, new_tx_data}), 32'd0);

    // Single requester, "ABCD", cycle-exact timing
    resetDut();
    len_val[0] = 5'd3;
    pushMsg(0);
    applyStimulus(4'b0001);
    waitQuiet(100, 1'b1);
    checkOutput("t1_grant_cycle", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
    checkOutput("t1_strobe_count", 32'(strobe_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < strobe_log.size(); k++) begin
      checkOutput("t1_strobe_cycle", 32'(strobe_log[k]), 32'(2 * (k + 1)));
    end
    checkOutput("t1_done_count", 32'(done_log.size()), 32'd1);
    checkOutput("t1_done_cycle", 32'(done_log.size() > 0 ? done_log[0] : -1), 32'd9);

    // All four requesting, one byte each: 0,1,2,3,0,1
    resetDut();
    for (int i = 0; i < NREQ; i++) len_val[i] = '0;
    pushMsg(0); pushMsg(1); pushMsg(2); pushMsg(3); pushMsg(0); pushMsg(1);
    applyStimulus(4'b1111);
    seen = 0;
    for (int n = 0; n < 200 && seen < 6; n++) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    req = '0;
    if (seen < 6) checkOutput("timeout_rr", 32'(seen), 32'd6);
    waitQuiet(50, 1'b0);
    checkOutput("rr_done_count", 32'(done_log.size()), 32'd6);

    // tx_busy held for 10 cycles after the 2nd byte of a 5-byte message
    resetDut();
    len_val[3] = 5'd4;
    pushMsg(3);
    applyStimulus(4'b1000);
    waitStrobes(2, 50);
    tx_busy = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("busy_no_strobe", 32'(new_tx_data), 32'd0);
      checkOutput("busy_hold_addr", 32'(rd_addr), 32'd2);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("busy_resume", 32'(new_tx_data), 32'd1);
    waitQuiet(100, 1'b1);

    // Maximum length message on requester 2
    resetDut();
    len_val[2] = 5'd31;
    pushMsg(2);
    applyStimulus(4'b0100);
    waitQuiet(200, 1'b1);
    checkOutput("len31_strobes", 32'(strobe_log.size()), 32'd32);
    checkOutput("len31_last_addr", 32'(last_addr), 32'd31);

    // Asynchronous reset mid-message, then restart from address 0
    resetDut();
    len_val[1] = 5'd4;
    pushMsg(1);
    applyStimulus(4'b0010);
    waitStrobes(2, 50);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_grant", 32'(grant), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("arst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("arst_strobe", 32'(new_tx_data), 32'd0);
    @(negedge clk);
    clearScoreboard();
    len_val[0] = 5'd3;
    pushMsg(0);
    pushMsg(1);
    req = 4'b0011;
    t0  = cyc;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("restart_grant", 32'(grant), 32'h1);
    checkOutput("restart_addr", 32'(rd_addr), 32'd0);
    waitQuiet(100, 1'b1);

    // req0 withdrawn during its message while req3 waits
    resetDut();
    len_val[0] = 5'd3;
    len_val[3] = 5'd2;
    pushMsg(0);
    pushMsg(3);
    applyStimulus(4'b1001);
    waitStrobes(1, 50);
    req[0] = 1'b0;
    waitQuiet(100, 1'b1);
    checkOutput("withdraw_grants", 32'(grant_log.size()), 32'd2);
    checkOutput("withdraw_dones", 32'(done_log.size()), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
